// File: rtl/proc_pkg.sv
// Shared definitions for the parametrised multi-cycle core: opcodes, FSM states
// and instruction field placement.
package proc_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLT  = 4'h5;
  localparam logic [3:0] OP_MVI  = 4'h7;
  localparam logic [3:0] OP_MV   = 4'h8;
  localparam logic [3:0] OP_MVNZ = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_LD   = 4'hB;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_FWAIT, S_DECODE, S_EX_G, S_WB,
    S_IMM, S_IWAIT, S_MEM, S_MWAIT, S_RETIRE
  } state_t;

  function automatic int rx_lsb();
    return 4;
  endfunction

  function automatic int ry_lsb(input int rw);
    return 4 + rw;
  endfunction

  function automatic logic is_alu(input logic [3:0] op);
    return op <= OP_SLT;
  endfunction

endpackage

// File: rtl/proc_regfile.sv
// NREG x DATA_W register file; the top register is the PC, which also has an
// increment port. A write to the PC wins over a simultaneous increment.
module proc_regfile
  import proc_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                NREG     = 8,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  localparam int               RW       = $clog2(NREG)
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              i_we,
  input  logic [RW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pc_inc,
  input  logic [RW-1:0]     i_raddr_x,
  input  logic [RW-1:0]     i_raddr_y,
  output logic [DATA_W-1:0] o_rdata_x,
  output logic [DATA_W-1:0] o_rdata_y,
  output logic [DATA_W-1:0] o_pc
);

  logic [NREG-1:0][DATA_W-1:0] w_regs;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      logic [DATA_W-1:0] r_q;
      if (gi == NREG - 1) begin : g_pc
        always_ff @(posedge clock or negedge resetN) begin
          if (!resetN)                                 r_q <= RESET_PC;
          else if (i_we && i_waddr == RW'(gi))         r_q <= i_wdata;
          else if (i_pc_inc)                           r_q <= r_q + 1'b1;
        end
      end else begin : g_gpr
        always_ff @(posedge clock or negedge resetN) begin
          if (!resetN)                                 r_q <= '0;
          else if (i_we && i_waddr == RW'(gi))         r_q <= i_wdata;
        end
      end
      assign w_regs[gi] = r_q;
    end
  endgenerate

  assign o_rdata_x = w_regs[i_raddr_x];
  assign o_rdata_y = w_regs[i_raddr_y];
  assign o_pc      = w_regs[NREG-1];

endmodule

// File: rtl/proc_core_param.sv
// Multi-cycle processor core with a req/ready memory handshake. One instruction
// at a time; done pulses for one cycle in RETIRE.
module proc_core_param
  import proc_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                NREG     = 8,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              run,
  input  logic [DATA_W-1:0] DIN,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              W,
  output logic [DATA_W-1:0] ADDR,
  output logic [DATA_W-1:0] DOUT,
  output logic              done
);

  localparam int RW     = $clog2(NREG);
  localparam int RX_LSB = rx_lsb();
  localparam int RY_LSB = ry_lsb(RW);
  localparam int IRW    = RY_LSB + RW;

  state_t            r_state, w_state_next;
  logic [IRW-1:0]    r_ir, w_ir_next;
  logic [DATA_W-1:0] r_a, w_a_next, r_g, w_g_next;
  logic [DATA_W-1:0] r_addr, w_addr_next, r_dout, w_dout_next;
  logic              r_w, w_w_next, r_req, w_req_next, r_done, w_done_next;

  logic [3:0]        w_op;
  logic [RW-1:0]     w_rx, w_ry;
  logic [DATA_W-1:0] w_rx_val, w_ry_val, w_pc, w_alu, w_rf_wdata;
  logic              w_rf_we, w_pc_inc, w_xfer;

  assign w_op   = r_ir[3:0];
  assign w_rx   = r_ir[RX_LSB +: RW];
  assign w_ry   = r_ir[RY_LSB +: RW];
  assign w_xfer = r_req & mem_ready;

  proc_regfile #(.DATA_W(DATA_W), .NREG(NREG), .RESET_PC(RESET_PC)) u_regfile (
    .clock     (clock),
    .resetN    (resetN),
    .i_we      (w_rf_we),
    .i_waddr   (w_rx),
    .i_wdata   (w_rf_wdata),
    .i_pc_inc  (w_pc_inc),
    .i_raddr_x (w_rx),
    .i_raddr_y (w_ry),
    .o_rdata_x (w_rx_val),
    .o_rdata_y (w_ry_val),
    .o_pc      (w_pc)
  );

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = r_a + w_ry_val;
      OP_SUB:  w_alu = r_a - w_ry_val;
      OP_AND:  w_alu = r_a & w_ry_val;
      OP_OR:   w_alu = r_a | w_ry_val;
      OP_XOR:  w_alu = r_a ^ w_ry_val;
      OP_SLT:  w_alu = DATA_W'($signed(r_a) < $signed(w_ry_val));
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_ir_next    = r_ir;
    w_a_next     = r_a;
    w_g_next     = r_g;
    w_addr_next  = r_addr;
    w_dout_next  = r_dout;
    w_w_next     = r_w;
    w_req_next   = r_req;
    w_rf_we      = 1'b0;
    w_rf_wdata   = w_ry_val;
    w_pc_inc     = 1'b0;
    case (r_state)
      S_IDLE:  if (run) w_state_next = S_FETCH;
      S_FETCH: begin
        w_addr_next  = w_pc;
        w_w_next     = 1'b0;
        w_req_next   = 1'b1;
        w_state_next = S_FWAIT;
      end
      S_FWAIT: if (w_xfer) begin
        w_req_next   = 1'b0;
        w_ir_next    = DIN[IRW-1:0];
        w_pc_inc     = 1'b1;
        w_state_next = S_DECODE;
      end
      // The DECODE cycle already has RX on the read port, so A is captured here.
      S_DECODE: begin
        w_state_next = S_RETIRE;
        if (is_alu(w_op)) begin
          w_a_next     = w_rx_val;
          w_state_next = S_EX_G;
        end else begin
          case (w_op)
            OP_MV:        w_rf_we = 1'b1;
            OP_MVNZ:      w_rf_we = (r_g != '0);
            OP_MVI:       w_state_next = S_IMM;
            OP_ST, OP_LD: w_state_next = S_MEM;
            default:      w_state_next = S_RETIRE;
          endcase
        end
      end
      S_EX_G: begin
        w_g_next     = w_alu;
        w_state_next = S_WB;
      end
      S_WB: begin
        w_rf_we      = 1'b1;
        w_rf_wdata   = r_g;
        w_state_next = S_RETIRE;
      end
      S_IMM: begin
        w_addr_next  = w_pc;
        w_w_next     = 1'b0;
        w_req_next   = 1'b1;
        w_state_next = S_IWAIT;
      end
      S_IWAIT: if (w_xfer) begin
        w_req_next   = 1'b0;
        w_rf_we      = 1'b1;
        w_rf_wdata   = DIN;
        w_pc_inc     = 1'b1;
        w_state_next = S_RETIRE;
      end
      S_MEM: begin
        w_addr_next  = w_ry_val;
        w_w_next     = (w_op == OP_ST);
        if (w_op == OP_ST) w_dout_next = w_rx_val;
        w_req_next   = 1'b1;
        w_state_next = S_MWAIT;
      end
      S_MWAIT: if (w_xfer) begin
        w_req_next   = 1'b0;
        w_rf_we      = (w_op == OP_LD);
        w_rf_wdata   = DIN;
        w_state_next = S_RETIRE;
      end
      S_RETIRE: w_state_next = run ? S_FETCH : S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
    // RETIRE is never re-entered from itself, so this is a single-cycle pulse.
    w_done_next = (w_state_next == S_RETIRE);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_ir   <= '0;
      r_a    <= '0;
      r_g    <= '0;
      r_addr <= '0;
      r_dout <= '0;
      r_w    <= 1'b0;
      r_req  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_ir   <= w_ir_next;
      r_a    <= w_a_next;
      r_g    <= w_g_next;
      r_addr <= w_addr_next;
      r_dout <= w_dout_next;
      r_w    <= w_w_next;
      r_req  <= w_req_next;
      r_done <= w_done_next;
    end
  end

  assign mem_req = r_req;
  assign W       = r_w;
  assign ADDR    = r_addr;
  assign DOUT    = r_dout;
  assign done    = r_done;

endmodule
